// File: rtl/line_fill_adaptor.sv
// line_fill_adaptor: bridges a 256-bit cache line port to a 64-bit burst port.
// Fills assemble four beats into a line; writebacks serialise a line into four beats.
module line_fill_adaptor #(
    parameter int s_offset = 5,
    parameter int s_burst  = 64,
    localparam int s_line  = 8 * 2**s_offset,
    localparam int n_beats = s_line / s_burst,
    localparam int cnt_w   = $clog2(n_beats)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       address_i,
    input  logic [s_line-1:0] line_i,
    input  logic              read_i,
    input  logic              write_i,
    output logic [s_line-1:0] line_o,
    output logic              resp_o,
    output logic [31:0]       address_o,
    input  logic [s_burst-1:0] burst_i,
    output logic [s_burst-1:0] burst_o,
    output logic              read_o,
    output logic              write_o,
    input  logic              resp_i
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WBACK,
        DONE
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [cnt_w-1:0]  cnt;
    logic [s_line-1:0] line_buf;
    logic [31:0]       addr;
    logic              last;
    logic              unused_low;

    // Byte offset within the line never reaches memory.
    assign unused_low = ^address_i[s_offset-1:0];

    assign last      = (cnt == cnt_w'(n_beats - 1));
    assign line_o    = line_buf;
    assign address_o = addr;
    assign burst_o   = line_buf[int'(cnt)*s_burst +: s_burst];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and handshake outputs, decoded from state only.
    always_comb begin
        state_n = state;
        read_o  = 1'b0;
        write_o = 1'b0;
        resp_o  = 1'b0;
        unique case (state)
            IDLE: begin
                if (write_i) begin
                    state_n = WBACK;
                end else if (read_i) begin
                    state_n = FILL;
                end
            end
            FILL: begin
                read_o = 1'b1;
                if (resp_i && last) begin
                    state_n = DONE;
                end
            end
            WBACK: begin
                write_o = 1'b1;
                if (resp_i && last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                resp_o  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Line buffer, line address and beat counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_buf <= '0;
            addr     <= '0;
            cnt      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (write_i) begin
                        line_buf <= line_i;
                        addr     <= {address_i[31:s_offset], s_offset'(0)};
                        cnt      <= '0;
                    end else if (read_i) begin
                        addr <= {address_i[31:s_offset], s_offset'(0)};
                        cnt  <= '0;
                    end
                end
                FILL: begin
                    if (resp_i) begin
                        line_buf[int'(cnt)*s_burst +: s_burst] <= burst_i;
                        cnt <= cnt + 1'b1;
                    end
                end
                WBACK: begin
                    if (resp_i) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_fill_adaptor.sv
// tb_line_fill_adaptor: scenario tasks plus randomized transactions
// checked against a transaction-level model of the line/beat mapping.
module tb_line_fill_adaptor;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  address_i = '0;
    logic [255:0] line_i = '0;
    logic         read_i = 1'b0;
    logic         write_i = 1'b0;
    logic [255:0] line_o;
    logic         resp_o;
    logic [31:0]  address_o;
    logic [63:0]  burst_i = '0;
    logic [63:0]  burst_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i = 1'b0;

    int errors = 0;
    int checks = 0;

    line_fill_adaptor dut (
        .clk(clk),
        .rst(rst),
        .address_i(address_i),
        .line_i(line_i),
        .read_i(read_i),
        .write_i(write_i),
        .line_o(line_o),
        .resp_o(resp_o),
        .address_o(address_o),
        .burst_i(burst_i),
        .burst_o(burst_o),
        .read_o(read_o),
        .write_o(write_o),
        .resp_i(resp_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [63:0] rand_beat();
        return {$urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            read_i    = 1'($urandom);
            write_i   = 1'($urandom);
            resp_i    = 1'($urandom);
            address_i = $urandom;
            line_i    = rand_line();
            burst_i   = rand_beat();
            tick();
        end
        checks++;
        if ({read_o, write_o, resp_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl got=%b want=000", {read_o, write_o, resp_o});
        end
        checks++;
        if (line_o !== '0 || address_o !== '0 || burst_o !== '0) begin
            errors++;
            $display("FAIL reset_data line=%h addr=%h burst=%h want 0",
                     line_o, address_o, burst_o);
        end
        read_i = 0; write_i = 0; resp_i = 0;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (read_o !== 1'b0 || write_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release rd=%b wr=%b want 0", read_o, write_o);
        end
    endtask

    task automatic test_fill_no_stall();
        logic [63:0] b [4];
        b[0] = {16{4'h1}}; b[1] = {16{4'h2}};
        b[2] = {16{4'h3}}; b[3] = {16{4'h4}};
        read_i = 1; address_i = 32'h0000_1234;
        tick();
        read_i = 0;
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (read_o !== 1 || resp_o !== 0 || address_o !== 32'h0000_1220) begin
                errors++;
                $display("FAIL fill_cyc%0d rd=%b resp=%b addr=%h want 1 0 00001220",
                         c, read_o, resp_o, address_o);
            end
            resp_i = 1; burst_i = b[c-1];
            tick();
        end
        resp_i = 0;
        checks++;
        if (resp_o !== 1 || read_o !== 0 || address_o !== 32'h0000_1220) begin
            errors++;
            $display("FAIL fill_done resp=%b rd=%b addr=%h", resp_o, read_o, address_o);
        end
        checks++;
        if (line_o !== {b[3], b[2], b[1], b[0]}) begin
            errors++;
            $display("FAIL fill_line got=%h want=%h", line_o, {b[3], b[2], b[1], b[0]});
        end
        tick();
        checks++;
        if (resp_o !== 0 || read_o !== 0) begin
            errors++;
            $display("FAIL fill_idle resp=%b rd=%b want 0 0", resp_o, read_o);
        end
    endtask

    task automatic test_wback_stalls();
        logic [63:0] exp_b [7];
        logic        pat [7];
        exp_b = '{64'hA, 64'hB, 64'hB, 64'hB, 64'hC, 64'hD, 64'hD};
        pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        write_i = 1; address_i = 32'hABCD_EF7F;
        line_i = {64'hD, 64'hC, 64'hB, 64'hA};
        tick();
        write_i = 0; line_i = rand_line();
        for (int c = 0; c < 7; c++) begin
            checks++;
            if (write_o !== 1 || resp_o !== 0 || burst_o !== exp_b[c]
                || address_o !== 32'hABCD_EF60) begin
                errors++;
                $display("FAIL wback_cyc%0d wr=%b resp=%b burst=%h want 1 0 %h addr=%h",
                         c + 1, write_o, resp_o, burst_o, exp_b[c], address_o);
            end
            resp_i = pat[c];
            tick();
        end
        resp_i = 0;
        checks++;
        if (resp_o !== 1 || write_o !== 0) begin
            errors++;
            $display("FAIL wback_done cyc8 resp=%b wr=%b want 1 0", resp_o, write_o);
        end
        tick();
        checks++;
        if (resp_o !== 0 || write_o !== 0) begin
            errors++;
            $display("FAIL wback_idle cyc9 resp=%b wr=%b want 0 0", resp_o, write_o);
        end
    endtask

    task automatic test_simultaneous();
        logic [255:0] l;
        l = rand_line();
        read_i = 1; write_i = 1; line_i = l; address_i = 32'h0000_0040;
        tick();
        read_i = 0; write_i = 0;
        checks++;
        if (write_o !== 1 || read_o !== 0) begin
            errors++;
            $display("FAIL simul_prio wr=%b rd=%b want 1 0", write_o, read_o);
        end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (burst_o !== l[c*64 +: 64]) begin
                errors++;
                $display("FAIL simul_beat%0d got=%h want=%h", c, burst_o, l[c*64 +: 64]);
            end
            resp_i = 1;
            tick();
        end
        resp_i = 0;
        checks++;
        if (resp_o !== 1) begin
            errors++;
            $display("FAIL simul_done resp=%b want 1", resp_o);
        end
        tick();
    endtask

    task automatic test_mid_change();
        logic [63:0]  b [4];
        logic [31:0]  a2;
        for (int i = 0; i < 4; i++) b[i] = rand_beat();
        read_i = 1; address_i = 32'h1000_0005;
        tick();
        for (int c = 0; c < 4; c++) begin
            address_i = $urandom; line_i = rand_line(); write_i = 1'($urandom);
            resp_i = 1; burst_i = b[c];
            tick();
        end
        resp_i = 0; write_i = 0;
        a2 = 32'h2000_0123;
        address_i = a2;
        checks++;
        if (resp_o !== 1 || address_o !== 32'h1000_0000
            || line_o !== {b[3], b[2], b[1], b[0]}) begin
            errors++;
            $display("FAIL mid_done resp=%b addr=%h line=%h", resp_o, address_o, line_o);
        end
        tick();
        checks++;
        if (read_o !== 0 || resp_o !== 0) begin
            errors++;
            $display("FAIL mid_idle rd=%b resp=%b want 0 0", read_o, resp_o);
        end
        tick();
        read_i = 0;
        checks++;
        if (read_o !== 1 || address_o !== 32'h2000_0120) begin
            errors++;
            $display("FAIL mid_refill rd=%b addr=%h want 1 20000120", read_o, address_o);
        end
        for (int c = 0; c < 4; c++) begin
            resp_i = 1; burst_i = rand_beat();
            tick();
        end
        resp_i = 0;
        tick();
    endtask

    task automatic test_reset_midburst();
        logic [63:0] b [4];
        int          seen;
        read_i = 1; address_i = 32'h0000_3000;
        tick();
        read_i = 0;
        for (int c = 0; c < 2; c++) begin
            resp_i = 1; burst_i = rand_beat();
            tick();
        end
        resp_i = 0;
        rst = 0;
        #1;
        checks++;
        if ({read_o, write_o, resp_o} !== 3'b000 || line_o !== '0
            || address_o !== '0 || burst_o !== '0) begin
            errors++;
            $display("FAIL rst_mid rd=%b wr=%b resp=%b line=%h addr=%h",
                     read_o, write_o, resp_o, line_o, address_o);
        end
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (resp_o) seen++;
        end
        rst = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (resp_o) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rst_noresp got=%0d pulses want=0", seen);
        end
        for (int i = 0; i < 4; i++) b[i] = rand_beat();
        read_i = 1; address_i = 32'h0000_5555;
        tick();
        read_i = 0;
        for (int c = 0; c < 4; c++) begin
            resp_i = 1; burst_i = b[c];
            tick();
        end
        resp_i = 0;
        checks++;
        if (resp_o !== 1 || line_o !== {b[3], b[2], b[1], b[0]}
            || address_o !== 32'h0000_5540) begin
            errors++;
            $display("FAIL rst_refill resp=%b line=%h addr=%h", resp_o, line_o, address_o);
        end
        tick();
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            logic         wr;
            logic [31:0]  a;
            logic [31:0]  ea;
            logic [255:0] l;
            logic [255:0] exp_line;
            int           k;
            int           cyc;
            logic         ok;
            wr = 1'($urandom);
            a  = $urandom;
            ea = a & 32'hFFFF_FFE0;
            l  = rand_line();
            exp_line = wr ? l : 256'h0;
            write_i = wr;
            read_i  = wr ? 1'($urandom) : 1'b1;
            address_i = a; line_i = l;
            tick();
            read_i = 0; write_i = 0;
            k = 0; cyc = 0; ok = 1;
            while (k < 4 && cyc < 40) begin
                logic [63:0] bt;
                if (read_o !== !wr || write_o !== wr || resp_o !== 0
                    || address_o !== ea) ok = 0;
                if (wr && burst_o !== l[k*64 +: 64]) ok = 0;
                address_i = $urandom; line_i = rand_line();
                bt = rand_beat();
                resp_i = ($urandom_range(0, 2) != 0);
                burst_i = bt;
                tick();
                if (resp_i) begin
                    if (!wr) exp_line[k*64 +: 64] = bt;
                    k++;
                end
                cyc++;
            end
            resp_i = 0;
            checks++;
            if (!ok || k != 4) begin
                errors++;
                $display("FAIL rand%0d_burst wr=%b beats=%0d of 4 in %0d cycles", t, wr, k, cyc);
            end
            checks++;
            if (resp_o !== 1 || read_o !== 0 || write_o !== 0
                || line_o !== exp_line || address_o !== ea) begin
                errors++;
                $display("FAIL rand%0d_done resp=%b line=%h want=%h", t, resp_o, line_o, exp_line);
            end
            tick();
            checks++;
            if (resp_o !== 0) begin
                errors++;
                $display("FAIL rand%0d_idle resp=%b want 0", t, resp_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_no_stall();
        test_wback_stalls();
        test_simultaneous();
        test_mid_change();
        test_reset_midburst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/line_fill_adaptor.md
# line_fill_adaptor

Bridges the cache datapath's 256-bit line interface to the 64-bit burst memory port. On a miss it assembles four memory beats into one line for the data array's `datain`. On a writeback it serialises a dirty line from the data array's `dataout` into four beats. A single FSM owns each transaction and signals completion to the cache controller with a one-cycle `resp_o`.

## Interface

**Parameters**
- s_offset, 5: log2 bytes per line. Line width is s_line = 8*2**s_offset = 256.
- s_burst, 64: beat width in bits. Beat count is n_beats = s_line/s_burst = 4, a power of two and at least 2.

**Ports**
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset; clears all state immediately when low
- address_i  in  32  cache-side byte address of the line
- line_i  in  s_line  line to write back, from data array `dataout`
- read_i  in  1  cache requests a line fill
- write_i  in  1  cache requests a writeback
- line_o  out  s_line  assembled fill line, to data array `datain`
- resp_o  out  1  one-cycle done pulse to the cache controller
- address_o  out  32  line-aligned memory address
- burst_i  in  s_burst  memory read beat
- burst_o  out  s_burst  memory write beat
- read_o  out  1  memory read request
- write_o  out  1  memory write request
- resp_i  in  1  memory beat accepted or valid this cycle

## Operation

**States:** IDLE, FILL, WBACK, DONE. A 2-bit beat counter `cnt` and a 256-bit `buf` register back all four states.

**IDLE**
- Samples read_i and write_i every cycle.
- If write_i is high:
  - latch `buf <= line_i`
  - latch `addr <= {address_i[31:s_offset], '0}`
  - clear `cnt`
  - go to WBACK
- Else if read_i is high: latch `addr`, clear `cnt`, go to FILL.
- write_i has priority when both are high.
- resp_i is ignored.

**FILL**
- read_o = 1 and address_o = addr.
- On each cycle with resp_i = 1: `buf[cnt*s_burst +: s_burst] <= burst_i` and `cnt++`.
- Beat 0 is the least-significant 64 bits.
- Cycles with resp_i = 0 are stalls: no change.
- When resp_i = 1 and cnt == n_beats-1, go to DONE.

**WBACK**
- write_o = 1, address_o = addr, and `burst_o = buf[cnt*s_burst +: s_burst]`.
- Each resp_i = 1 advances `cnt`.
- The last beat goes to DONE.

**DONE**
- resp_o = 1 for exactly one cycle, then return to IDLE.
- read_o and write_o are 0.

**Output behaviour**
- line_o = buf at all times.
- After a fill, line_o holds the assembled line until the next transaction overwrites buf. The cache writes the data array during the resp_o cycle.
- address_o = addr in every state. It stays stable for the whole transaction.
- read_i, write_i, address_i and line_i are ignored outside IDLE. Changes mid-transaction have no effect.
- The cache must drop its request in the resp_o cycle. A request still high in the following IDLE cycle starts a new transaction.

**Reset**
- Applies from any state, including mid-burst.
- state = IDLE, cnt = 0, buf = 0, addr = 0.
- All outputs are 0, so line_o = 0, address_o = 0 and burst_o = 0.
- A partial burst is abandoned. No resp_o is issued.

## Timing

- read_o, write_o and resp_o are decoded from the registered state only; no combinational path runs from any input.
- burst_o and line_o come from registers.
- **Latency, zero memory stalls.** Request high in cycle 0:
  - read_o or write_o is high in cycles 1–4
  - resp_i is high in cycles 1–4
  - resp_o is high in cycle 5
  - IDLE again in cycle 6
- **Latency with stalls:** 2 + n_beats + (number of resp_i = 0 cycles in FILL/WBACK).
- burst_o changes in the cycle after the resp_i that accepted the previous beat.
- The counter wraps to 0 on the last beat. No extra beat is issued.
- Throughput: at most one transaction every n_beats+2 cycles.

## Test plan

- **Reset values.** Hold rst low for 3 cycles with random inputs → all outputs 0 and the FSM in IDLE. Release → read_o = 0 until a request arrives.
- **Fill, no stalls.**
  - Stimulus: read_i = 1, address_i = 0x0000_1234.
  - Beats 0x11…11, 0x22…22, 0x33…33, 0x44…44, with resp_i high in cycles 1–4.
  - Required: address_o = 0x0000_1220 throughout and resp_o high only in cycle 5.
  - Required: line_o = {0x44…44, 0x33…33, 0x22…22, 0x11…11}.
- **Writeback with stalls.**
  - Stimulus: write_i = 1, line_i = {64'hD, 64'hC, 64'hB, 64'hA}, resp_i pattern 1,0,0,1,1,0,1.
  - Required: burst_o sequence A, B, B, B, C, D, D with write_o held high.
  - Required: resp_o one cycle after the 4th accepted beat, total latency 9.
- **Simultaneous requests.** read_i = write_i = 1 in IDLE → WBACK taken: write_o = 1, read_o = 0.
- **Mid-transaction input changes.** Change address_i and line_i during FILL → address_o and collected beats are unaffected. Hold read_i high through the resp_o cycle → a second FILL starts on the next cycle.
- **Reset mid-burst.** Assert rst after beat 2 of a fill → outputs 0 immediately and no resp_o. A following fill completes normally with correct data.
